// File: rtl/legup_div_sequential.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : legup_div_sequential                                          |
// | Purpose  : Multi-cycle radix-2 restoring integer divider, one quotient   |
// |            bit per enabled clock, start/done handshake, clken stall.     |
// | Ports    : clock, aclr (sync, active-high), clken, start,                |
// |            numer[widthn], denom[widthd] -> busy, done,                   |
// |            quotient[widthn], remain[widthd]                              |
// |            div_by_zero (only when LEGUP_DIV_ZERO_FLAG_EN is defined)     |
// | Config   : `define LEGUP_DIV_ZERO_FLAG_EN adds the div_by_zero output.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module legup_div_sequential #(
   parameter int    widthn         = 32,
   parameter int    widthd         = 32,
   parameter string representation = "UNSIGNED"
) (
   input  logic              clock,
   input  logic              aclr,
   input  logic              clken,
   input  logic              start,
   input  logic [widthn-1:0] numer,
   input  logic [widthd-1:0] denom,
   output logic              busy,
   output logic              done,
   output logic [widthn-1:0] quotient,
   output logic [widthd-1:0] remain
`ifdef LEGUP_DIV_ZERO_FLAG_EN
   ,
   output logic              div_by_zero
`endif
);

   localparam bit IS_SIGNED = (representation == "SIGNED");
   localparam int CNT_W     = $clog2(widthn + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   // Holds the numerator magnitude; quotient bits shift in at the bottom as
   // numerator bits leave from the top, so it ends up holding |quotient|.
   logic [widthn-1:0]   num_q, num_d;
   logic [widthd-1:0]   den_q, den_d;
   logic [widthd-1:0]   rem_q, rem_d;
   logic [widthd-1:0]   numer_lo_q, numer_lo_d;
   logic                q_neg_q, q_neg_d;
   logic                r_neg_q, r_neg_d;
   logic                dz_q, dz_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [widthn-1:0]   quotient_q, quotient_d;
   logic [widthd-1:0]   remain_q, remain_d;
`ifdef LEGUP_DIV_ZERO_FLAG_EN
   logic                div_by_zero_q, div_by_zero_d;
`endif

   // Partial remainder after the shift is widthd+1 bits wide. The compare
   // uses all bits; the subtraction only needs the low widthd bits because a
   // successful trial result is always below |denom|.
   logic [widthd:0]     w_rem_shift;
   logic                w_ge;
   logic [widthd-1:0]   w_sub;

   assign w_rem_shift = {rem_q, num_q[widthn-1]};
   assign w_ge        = (w_rem_shift >= {1'b0, den_q});
   assign w_sub       = w_rem_shift[widthd-1:0] - den_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      num_d      = num_q;
      den_d      = den_q;
      rem_d      = rem_q;
      numer_lo_d = numer_lo_q;
      q_neg_d    = q_neg_q;
      r_neg_d    = r_neg_q;
      dz_d       = dz_q;
      busy_d     = busy_q;
      done_d     = done_q;
      quotient_d = quotient_q;
      remain_d   = remain_q;
`ifdef LEGUP_DIV_ZERO_FLAG_EN
      div_by_zero_d = div_by_zero_q;
`endif
      if (clken) begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  num_d      = (IS_SIGNED && numer[widthn-1]) ? ({widthn{1'b0}} - numer) : numer;
                  den_d      = (IS_SIGNED && denom[widthd-1]) ? ({widthd{1'b0}} - denom) : denom;
                  rem_d      = '0;
                  cnt_d      = CNT_W'(widthn);
                  q_neg_d    = IS_SIGNED && (numer[widthn-1] ^ denom[widthd-1]);
                  r_neg_d    = IS_SIGNED && numer[widthn-1];
                  dz_d       = (denom == '0);
                  numer_lo_d = numer[widthd-1:0];
                  busy_d     = 1'b1;
                  state_d    = S_CALC;
               end
            end
            S_CALC: begin
               rem_d = w_ge ? w_sub : w_rem_shift[widthd-1:0];
               num_d = {num_q[widthn-2:0], w_ge};
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = S_FIX;
               end
            end
            S_FIX: begin
               if (dz_q) begin
                  quotient_d = '1;
                  remain_d   = numer_lo_q;
               end else begin
                  // Most-negative / -1 needs no special case: the magnitude
                  // 2^(widthn-1) is not negated and reads back as itself.
                  quotient_d = q_neg_q ? ({widthn{1'b0}} - num_q) : num_q;
                  remain_d   = r_neg_q ? ({widthd{1'b0}} - rem_q) : rem_q;
               end
`ifdef LEGUP_DIV_ZERO_FLAG_EN
               div_by_zero_d = dz_q;
`endif
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_DONE;
            end
            S_DONE: begin
               done_d  = 1'b0;
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (aclr) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         num_q      <= '0;
         den_q      <= '0;
         rem_q      <= '0;
         numer_lo_q <= '0;
         q_neg_q    <= 1'b0;
         r_neg_q    <= 1'b0;
         dz_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         quotient_q <= '0;
         remain_q   <= '0;
`ifdef LEGUP_DIV_ZERO_FLAG_EN
         div_by_zero_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         num_q      <= num_d;
         den_q      <= den_d;
         rem_q      <= rem_d;
         numer_lo_q <= numer_lo_d;
         q_neg_q    <= q_neg_d;
         r_neg_q    <= r_neg_d;
         dz_q       <= dz_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         quotient_q <= quotient_d;
         remain_q   <= remain_d;
`ifdef LEGUP_DIV_ZERO_FLAG_EN
         div_by_zero_q <= div_by_zero_d;
`endif
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign quotient = quotient_q;
   assign remain   = remain_q;
`ifdef LEGUP_DIV_ZERO_FLAG_EN
   assign div_by_zero = div_by_zero_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_legup_div_sequential.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_legup_div_sequential                                       |
// | Purpose  : Self-checking bench for legup_div_sequential; one unsigned    |
// |            and one signed instance share the same stimulus.              |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_legup_div_sequential;

   localparam int NOPS = 1000;

   logic        clock = 1'b0;
   logic        aclr  = 1'b1;
   logic        clken = 1'b1;
   logic        start = 1'b0;
   logic [31:0] numer = '0;
   logic [31:0] denom = '0;
   logic        busy_u, done_u, busy_s, done_s;
   logic [31:0] quo_u, rem_u, quo_s, rem_s;
`ifdef LEGUP_DIV_ZERO_FLAG_EN
   logic        dz_u, dz_s;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   legup_div_sequential #(.widthn(32), .widthd(32), .representation("UNSIGNED")) dut_u (
      .clock(clock), .aclr(aclr), .clken(clken), .start(start),
      .numer(numer), .denom(denom), .busy(busy_u), .done(done_u),
      .quotient(quo_u), .remain(rem_u)
`ifdef LEGUP_DIV_ZERO_FLAG_EN
      , .div_by_zero(dz_u)
`endif
   );

   legup_div_sequential #(.widthn(32), .widthd(32), .representation("SIGNED")) dut_s (
      .clock(clock), .aclr(aclr), .clken(clken), .start(start),
      .numer(numer), .denom(denom), .busy(busy_s), .done(done_s),
      .quotient(quo_s), .remain(rem_s)
`ifdef LEGUP_DIV_ZERO_FLAG_EN
      , .div_by_zero(dz_s)
`endif
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_res(input string tag, input logic [31:0] qu, input logic [31:0] ru,
                            input logic [31:0] qs, input logic [31:0] rs);
      check_eq({tag, "_q_u"}, quo_u, qu);
      check_eq({tag, "_r_u"}, rem_u, ru);
      check_eq({tag, "_q_s"}, quo_s, qs);
      check_eq({tag, "_r_s"}, rem_s, rs);
   endtask

   function automatic logic [63:0] model_u(input logic [31:0] n, input logic [31:0] d);
      if (d == 32'd0) return {32'hFFFF_FFFF, n};
      return {n / d, n % d};
   endfunction

   function automatic logic [63:0] model_s(input logic [31:0] n, input logic [31:0] d);
      int sn, sd, q, r;
      if (d == 32'd0) return {32'hFFFF_FFFF, n};
      if (n == 32'h8000_0000 && d == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0};
      sn = n;
      sd = d;
      q  = sn / sd;
      r  = sn % sd;
      return {q, r};
   endfunction

   // Issues one division. Edges after the accepting edge are numbered from 1;
   // clken is low for edges stall_at+1 .. stall_at+stall_len, and a decoy
   // start with other operands is driven at edge junk_at. cycles is the edge
   // count after which done was first seen (-1 on timeout).
   task automatic run_op(input logic [31:0] n, input logic [31:0] d,
                         input int stall_at, input int stall_len, input int junk_at,
                         input int hold_done, output int cycles, output int busy_cnt);
      numer = n;
      denom = d;
      clken = 1'b1;
      start = 1'b1;
      tick();
      start    = 1'b0;
      cycles   = -1;
      busy_cnt = busy_u ? 1 : 0;
      for (int i = 1; i <= 200; i++) begin
         clken = !(i > stall_at && i <= stall_at + stall_len);
         if (i == junk_at) begin
            start = 1'b1;
            numer = 32'd5;
            denom = 32'd1;
         end else begin
            start = 1'b0;
            numer = n;
            denom = d;
         end
         tick();
         if (done_u) begin
            cycles = i;
            break;
         end
         if (busy_u) busy_cnt++;
      end
      clken = 1'b1;
      start = 1'b0;
      check_eq("busy_at_done", busy_u, 1'b0);
      if (hold_done > 0) begin
         clken = 1'b0;
         repeat (hold_done) tick();
         check_eq("done_held_in_stall", done_u, 1'b1);
         clken = 1'b1;
      end
      tick();
      check_eq("done_one_cycle", done_u, 1'b0);
   endtask

   logic [31:0] op_n [NOPS];
   logic [31:0] op_d [NOPS];

   initial begin
      int          cyc, bc, cnt, t, t_prev;
      logic        got;
      logic [63:0] eu, es;

      // Reset, with start asserted to show aclr dominates.
      aclr  = 1'b1;
      start = 1'b1;
      numer = 32'd9;
      denom = 32'd3;
      repeat (3) tick();
      start = 1'b0;
      check_eq("rst_busy", busy_u, 1'b0);
      check_eq("rst_done", done_u, 1'b0);
      check_res("rst", 32'd0, 32'd0, 32'd0, 32'd0);
`ifdef LEGUP_DIV_ZERO_FLAG_EN
      check_eq("rst_dz", dz_u, 1'b0);
`endif
      aclr = 1'b0;
      tick();

      // Unsigned basic, including a done pulse stretched by a stall.
      run_op(32'd100, 32'd7, 0, 0, 0, 2, cyc, bc);
      check_eq("lat_100_7", cyc, 33);
      check_eq("busy_100_7", bc, 33);
      check_res("d100_7", 32'd14, 32'd2, 32'd14, 32'd2);
`ifdef LEGUP_DIV_ZERO_FLAG_EN
      check_eq("dz_clear", dz_u, 1'b0);
`endif

      // Signed truncation toward zero; remainder follows numerator sign.
      run_op(32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0, cyc, bc);
      check_eq("lat_m7_2", cyc, 33);
      check_res("dm7_2", 32'h7FFF_FFFC, 32'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);

      run_op(32'd7, 32'hFFFF_FFFE, 0, 0, 0, 0, cyc, bc);
      check_res("d7_m2", 32'd0, 32'd7, 32'hFFFF_FFFD, 32'd1);

      // Most-negative / -1 wraps.
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, cyc, bc);
      check_res("dmin_m1", 32'd0, 32'h8000_0000, 32'h8000_0000, 32'd0);

      // Divide by zero.
      run_op(32'h0000_1234, 32'd0, 0, 0, 0, 0, cyc, bc);
      check_res("dzero", 32'hFFFF_FFFF, 32'h1234, 32'hFFFF_FFFF, 32'h1234);
`ifdef LEGUP_DIV_ZERO_FLAG_EN
      check_eq("dz_u_set", dz_u, 1'b1);
      check_eq("dz_s_set", dz_s, 1'b1);
`endif

      // Stall of 5 cycles mid-CALC plus an ignored start during CALC.
      run_op(32'd1000, 32'd10, 10, 5, 20, 0, cyc, bc);
      check_eq("lat_stall", cyc, 38);
      check_eq("busy_stall", bc, 38);
      check_res("d1000_10", 32'd100, 32'd0, 32'd100, 32'd0);

      // Reset mid-operation at edge 10.
      numer = 32'd12346;
      denom = 32'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      aclr = 1'b1;
      tick();
      aclr = 1'b0;
      check_eq("abort_busy", busy_u, 1'b0);
      check_eq("abort_done", done_u, 1'b0);
      check_res("abort", 32'd0, 32'd0, 32'd0, 32'd0);
      cnt = 0;
      repeat (50) begin
         tick();
         if (done_u || done_s || busy_u) cnt++;
      end
      check_eq("abort_no_done", cnt, 0);
      run_op(32'd12346, 32'd3, 0, 0, 0, 0, cyc, bc);
      check_eq("lat_after_abort", cyc, 33);
      check_res("d12346_3", 32'd4115, 32'd1, 32'd4115, 32'd1);

      // Back-to-back with start held high.
      for (int k = 0; k < NOPS; k++) begin
         op_n[k] = $urandom;
         op_d[k] = $urandom;
         if (k % 3 == 0) op_d[k] = $urandom_range(1, 255);
         if (k % 5 == 1) op_d[k] = -$urandom_range(1, 255);
         if (k % 97 == 5) op_d[k] = 32'd0;
         if (k == 7) begin
            op_n[k] = 32'h8000_0000;
            op_d[k] = 32'hFFFF_FFFF;
         end
      end
      numer  = op_n[0];
      denom  = op_d[0];
      start  = 1'b1;
      t      = 0;
      t_prev = 0;
      for (int k = 0; k < NOPS; k++) begin
         got = 1'b0;
         for (int i = 0; i < 200; i++) begin
            tick();
            t++;
            if (done_u) begin
               got = 1'b1;
               break;
            end
         end
         if (!got) begin
            check_eq("b2b_timeout", 1'b0, 1'b1);
            break;
         end
         eu = model_u(op_n[k], op_d[k]);
         es = model_s(op_n[k], op_d[k]);
         check_res("b2b", eu[63:32], eu[31:0], es[63:32], es[31:0]);
         check_eq("b2b_done_s", done_s, 1'b1);
         if (k > 0) check_eq("b2b_period", t - t_prev, 35);
         else       check_eq("b2b_first", t, 34);
         t_prev = t;
         if (k + 1 < NOPS) begin
            numer = op_n[k + 1];
            denom = op_d[k + 1];
         end else begin
            start = 1'b0;
         end
      end
      tick();
      check_eq("b2b_end_done", done_u, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/legup_div_sequential.md
# legup_div_sequential

Multi-cycle integer divider: a radix-2 restoring datapath that computes one quotient bit per enabled clock. It is the division counterpart to the team's pipelined multiplier and is instantiated by generated HLS datapaths wherever a `/` or `%` operator is scheduled. Operands are accepted with a start/done handshake, and results are held until the next operation. A `clken` stall input freezes the whole block, matching the multiplier's enable semantics.

## Interface
- `widthn`, 32, numerator and quotient width in bits (≥2).
- `widthd`, 32, denominator and remainder width in bits (≥2, ≤ `widthn`).
- `representation`, "UNSIGNED", either "UNSIGNED" or "SIGNED" (two's complement).

- `clock`  in  1  sole clock; all logic on the rising edge.
- `aclr`  in  1  reset; synchronous, active-high.
- `clken`  in  1  clock enable; low freezes all state and outputs.
- `start`  in  1  request; sampled only in IDLE with `clken` high.
- `numer`  in  `widthn`  numerator; captured on an accepted start.
- `denom`  in  `widthd`  denominator; captured on an accepted start.
- `busy`  out  1  high from the cycle after acceptance until `done`.
- `done`  out  1  one-enabled-cycle pulse; results are valid from this cycle.
- `quotient`  out  `widthn`  registered quotient.
- `remain`  out  `widthd`  registered remainder.
- `div_by_zero`  out  1  present only with `LEGUP_DIV_ZERO_FLAG_EN`.

## Operation
- **Reset:** `aclr` high forces the following state.
  - State machine goes to IDLE.
  - `busy`, `done`, `quotient` and `remain` all go to 0; `div_by_zero` also goes to 0 when present.
  - `aclr` overrides `clken` and `start`.
  - Reset mid-operation abandons the division, and no `done` is produced for it.
- **States:** IDLE → CALC → FIX → DONE → IDLE.
  - **IDLE:** on `start & clken`, latch the operands, load the iteration counter with `widthn`, and go to CALC. `busy` is high on the following cycle.
  - **CALC:** each enabled cycle, shift the partial remainder left by 1 and bring in the next magnitude bit of the numerator. Trial-subtract the |denominator|. If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0. Decrement the counter; at 0, go to FIX.
  - **FIX:** apply signs and corner cases, then write `quotient` and `remain`, and go to DONE.
  - **DONE:** `done` is high and `busy` is low for this single cycle; return to IDLE. A `start` in this cycle is ignored.
- A `start` while not in IDLE is ignored; operands are not re-captured.
- **Unsigned mode:** the datapath works on the operands directly.
- **Signed mode:** the datapath works on magnitudes.
  - The quotient is negated when the operand signs differ; it truncates toward zero.
  - The remainder takes the sign of the numerator, which is C semantics.
- **Overflow:** in signed mode, the most-negative numerator divided by -1 gives quotient = most-negative value (wrap) and remainder = 0.
- **Divide by zero:** when `denom` is 0, FIX forces `quotient` to all ones and `remain` to `numer[widthd-1:0]`. This holds in both representations.
- `quotient` and `remain` hold their values until the next FIX or reset.
- The internal partial remainder is `widthd+1` bits wide, so no intermediate overflow occurs.

## Timing
- With a start accepted at enabled edge 0:
  - CALC occupies enabled edges 1..`widthn`.
  - FIX is at edge `widthn+1`.
  - `done` is high during the cycle after edge `widthn+1`, i.e. it is sampled high at edge `widthn+2`.
- Latency is `widthn+2` enabled cycles. The next start is accepted `widthn+3` cycles after the previous one at the earliest.
- `clken` low for N cycles extends the latency by exactly N cycles. During a stall, `done` and `busy` hold their current values, so a `done` pulse can stretch across disabled cycles.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- **Macro:** `LEGUP_DIV_ZERO_FLAG_EN`.
- **Defined:** the `div_by_zero` port exists.
  - It is written in FIX: 1 if the captured `denom` was 0, else 0.
  - It is held like `quotient` and cleared by `aclr`.
- **Undefined:** the port and its register are absent. Division-by-zero results are unchanged (all-ones quotient, numerator remainder).

## Test plan
- **Unsigned basic:** unsigned, `widthn`=`widthd`=32, numer=100, denom=7, start at edge 0 → `done` at edge 34, `quotient`=14, `remain`=2, `busy` high for edges 1–33.
- **Signed truncation:** signed, numer=-7, denom=2 → `quotient`=-3, `remain`=-1. Then numer=7, denom=-2 → `quotient`=-3, `remain`=1.
- **Corner cases:**
  - Signed, numer=0x80000000, denom=-1 → `quotient`=0x80000000, `remain`=0.
  - Any mode, denom=0, numer=0x1234 → `quotient`=0xFFFFFFFF, `remain`=0x1234, and `div_by_zero`=1 when the macro is defined.
- **Stall:** unsigned 1000/10 with `clken` low for 5 cycles mid-CALC → `done` at edge 39, `quotient`=100, `remain`=0. A `start` pulsed during CALC with other operands is ignored.
- **Reset mid-operation:** assert `aclr` at edge 10 of a division → next cycle `busy`=0, `done`=0, `quotient`=0, `remain`=0, and no `done` appears afterwards. A fresh start afterwards completes correctly in 34 cycles.
- **Back-to-back:** a `start` held continuously → operations are accepted every 35 cycles. `done` is high for exactly one cycle each time, and results match a reference model over 1000 random operand pairs in both representations.
